// File: rtl/stream_hist_bins.sv
// Streaming histogram: counts valid/ready samples into NUM_BINS programmable
// inclusive ranges, then drains the per-bin counts one at a time.
module stream_hist_bins #(
  parameter int DATA_W   = 8,
  parameter int NUM_BINS = 4,
  parameter int CNT_W    = 16,
  localparam int IDX_W   = $clog2(NUM_BINS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [DATA_W-1:0] cfg_lo,
  input  logic [DATA_W-1:0] cfg_hi,
  input  logic              start,
  input  logic              stop,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_idx,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_sat,
  output logic              busy,
  output logic              done
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BINS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, DRAIN = 2'd2} state_t;

  state_t            state_r;
  logic [DATA_W-1:0] lo_r  [NUM_BINS];
  logic [DATA_W-1:0] hi_r  [NUM_BINS];
  logic [CNT_W-1:0]  cnt_r [NUM_BINS];
  logic              sat_r [NUM_BINS];
  logic              s_ready_r, out_valid_r, busy_r, done_r;
  logic [IDX_W-1:0]  out_idx_r;

  // An inverted range (lo > hi) can never satisfy both comparisons.
  function automatic logic in_bin(input logic [DATA_W-1:0] v,
                                  input logic [DATA_W-1:0] lo,
                                  input logic [DATA_W-1:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // Control FSM, bound registers, per-bin counters and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      s_ready_r   <= 1'b0;
      out_valid_r <= 1'b0;
      out_idx_r   <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      for (int i = 0; i < NUM_BINS; i++) begin
        lo_r[i]  <= '0;
        hi_r[i]  <= '0;
        cnt_r[i] <= '0;
        sat_r[i] <= 1'b0;
      end
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (cfg_we && (int'(cfg_idx) < NUM_BINS)) begin
            lo_r[cfg_idx] <= cfg_lo;
            hi_r[cfg_idx] <= cfg_hi;
          end
          if (start) begin
            for (int i = 0; i < NUM_BINS; i++) begin
              cnt_r[i] <= '0;
              sat_r[i] <= 1'b0;
            end
            state_r   <= ACCUM;
            s_ready_r <= 1'b1;
            busy_r    <= 1'b1;
          end
        end
        ACCUM: begin
          if (s_valid) begin
            for (int i = 0; i < NUM_BINS; i++) begin
              if (in_bin(s_data, lo_r[i], hi_r[i]) && (cnt_r[i] != CNT_MAX)) begin
                cnt_r[i] <= cnt_r[i] + {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_r[i] == CNT_MAX - {{(CNT_W-1){1'b0}}, 1'b1}) begin
                  sat_r[i] <= 1'b1;
                end
              end
            end
          end
          if (stop) begin
            state_r     <= DRAIN;
            s_ready_r   <= 1'b0;
            out_valid_r <= 1'b1;
            out_idx_r   <= '0;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (out_idx_r == LAST_IDX) begin
              state_r     <= IDLE;
              out_valid_r <= 1'b0;
              out_idx_r   <= '0;
              busy_r      <= 1'b0;
              done_r      <= 1'b1;
            end else begin
              out_idx_r <= out_idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
            end
          end
        end
        default: begin
          state_r     <= IDLE;
          s_ready_r   <= 1'b0;
          out_valid_r <= 1'b0;
          out_idx_r   <= '0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  // Result data is a direct read of the selected bin, zeroed outside DRAIN.
  always_comb begin
    out_count = '0;
    out_sat   = 1'b0;
    if (out_valid_r) begin
      out_count = cnt_r[out_idx_r];
      out_sat   = sat_r[out_idx_r];
    end else begin
      out_count = '0;
      out_sat   = 1'b0;
    end
  end

  assign s_ready   = s_ready_r;
  assign out_valid = out_valid_r;
  assign out_idx   = out_idx_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_stream_hist_bins.sv
// Directed self-checking bench: a 4-bin/16-bit instance for the main checks and
// a 2-bin/4-bit instance for the two-bin drain and saturation corners.
module tb_stream_hist_bins;

  logic        clk = 1'b0;
  logic        rst_n, cfg_we, cfg_sel, start, stop, s_valid, out_ready;
  logic [1:0]  cfg_idx;
  logic [7:0]  cfg_lo, cfg_hi, s_data;
  logic        cfg_we_a, cfg_we_b;

  logic        s_ready, out_valid, out_sat, busy, done;
  logic [1:0]  out_idx;
  logic [15:0] out_count;
  logic        s_ready2, out_valid2, out_sat2, busy2, done2;
  logic [0:0]  out_idx2;
  logic [3:0]  out_count2;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign cfg_we_a = cfg_we & ~cfg_sel;
  assign cfg_we_b = cfg_we & cfg_sel;

  stream_hist_bins #(.DATA_W(8), .NUM_BINS(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we_a), .cfg_idx(cfg_idx),
    .cfg_lo(cfg_lo), .cfg_hi(cfg_hi), .start(start), .stop(stop),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_count(out_count), .out_sat(out_sat), .busy(busy), .done(done));

  stream_hist_bins #(.DATA_W(8), .NUM_BINS(2), .CNT_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we_b), .cfg_idx(cfg_idx[0:0]),
    .cfg_lo(cfg_lo), .cfg_hi(cfg_hi), .start(start), .stop(stop),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready2),
    .out_valid(out_valid2), .out_ready(out_ready), .out_idx(out_idx2),
    .out_count(out_count2), .out_sat(out_sat2), .busy(busy2), .done(done2));

  typedef struct packed {
    logic [3:0][7:0]  lo;
    logic [3:0][7:0]  hi;
    logic [7:0][7:0]  smp;
    logic [3:0]       n;
    logic [3:0][15:0] exp;
  } vec_t;

  vec_t vecs [3];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic sel, input logic [1:0] idx, input logic [7:0] lo, input logic [7:0] hi);
    cfg_sel = sel; cfg_idx = idx; cfg_lo = lo; cfg_hi = hi; cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  task automatic push(input logic [7:0] v);
    s_valid = 1'b1; s_data = v; tick(); s_valid = 1'b0;
  endtask

  // Drain all four bins of the main instance with out_ready held high.
  task automatic drain4(input logic [3:0][15:0] exp, input string tag);
    out_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      chk({tag, "_valid"}, out_valid, 1'b1);
      chk({tag, "_idx"}, out_idx, b);
      chk({tag, "_count"}, out_count, exp[b]);
      chk({tag, "_sat"}, out_sat, 1'b0);
      tick();
    end
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_valid_end"}, out_valid, 1'b0);
    chk({tag, "_busy_end"}, busy, 1'b0);
    tick();
    chk({tag, "_done_once"}, done, 1'b0);
    out_ready = 1'b0;
  endtask

  task automatic settle();
    out_ready = 1'b1;
    repeat (4) tick();
    out_ready = 1'b0;
  endtask

  initial begin
    int pat [8];
    int m;
    logic [3:0][15:0] exp5;

    vecs[0].lo = {8'd255, 8'd20, 8'd9, 8'd0};
    vecs[0].hi = {8'd0, 8'd10, 8'd12, 8'd9};
    vecs[0].smp = {8'd0, 8'd0, 8'd0, 8'd9, 8'd11, 8'd3, 8'd12, 8'd1};
    vecs[0].n = 4'd5;
    vecs[0].exp = {16'd0, 16'd0, 16'd3, 16'd3};
    vecs[1].lo = {8'd0, 8'd16, 8'd4, 8'd0};
    vecs[1].hi = {8'd255, 8'd255, 8'd15, 8'd3};
    vecs[1].smp = {8'd0, 8'd16, 8'd15, 8'd200, 8'd1, 8'd1, 8'd4, 8'd0};
    vecs[1].n = 4'd7;
    vecs[1].exp = {16'd7, 16'd2, 16'd2, 16'd3};
    vecs[2].lo = {8'd254, 8'd255, 8'd0, 8'd5};
    vecs[2].hi = {8'd255, 8'd255, 8'd0, 8'd5};
    vecs[2].smp = {8'd0, 8'd5, 8'd254, 8'd255, 8'd0, 8'd6, 8'd4, 8'd5};
    vecs[2].n = 4'd7;
    vecs[2].exp = {16'd2, 16'd1, 16'd1, 16'd2};

    rst_n = 1'b0; cfg_we = 1'b0; cfg_sel = 1'b0; cfg_idx = 2'd0; cfg_lo = 8'd0;
    cfg_hi = 8'd0; start = 1'b0; stop = 1'b0; s_valid = 1'b0; s_data = 8'd0;
    out_ready = 1'b0;
    #2;
    chk("rst_s_ready", s_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_idx", out_idx, 2'd0);
    chk("rst_out_count", out_count, 16'd0);
    chk("rst_out_sat", out_sat, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    #10 rst_n = 1'b1;
    tick();
    pulse_stop();
    chk("idle_stop_ignored", busy, 1'b0);

    // Table-driven runs on the 4-bin instance
    for (int v = 0; v < 3; v++) begin
      for (int b = 0; b < 4; b++) cfg(1'b0, 2'(b), vecs[v].lo[b], vecs[v].hi[b]);
      pulse_start();
      chk("vec_s_ready", s_ready, 1'b1);
      chk("vec_busy", busy, 1'b1);
      for (int i = 0; i < int'(vecs[v].n); i++) push(vecs[v].smp[i]);
      pulse_stop();
      chk("vec_s_ready_drop", s_ready, 1'b0);
      drain4(vecs[v].exp, $sformatf("vec%0d", v));
    end

    // Stop coincident with the fifth sample; s_valid held afterwards
    cfg(1'b0, 2'd0, 8'd0, 8'd7);
    for (int b = 1; b < 4; b++) cfg(1'b0, 2'(b), 8'd255, 8'd0);
    pulse_start();
    for (int i = 1; i <= 4; i++) push(8'(i));
    chk("t4_ready_before_stop", s_ready, 1'b1);
    s_valid = 1'b1; s_data = 8'd5; stop = 1'b1;
    tick();
    stop = 1'b0; s_data = 8'd6;
    chk("t4_ready_after_stop", s_ready, 1'b0);
    repeat (3) tick();
    s_valid = 1'b0;
    chk("t4_count_held", out_count, 16'd5);
    drain4({16'd0, 16'd0, 16'd0, 16'd5}, "t4");

    // Back-pressured drain
    cfg(1'b0, 2'd0, 8'd0, 8'd7);
    cfg(1'b0, 2'd1, 8'd0, 8'd3);
    cfg(1'b0, 2'd2, 8'd4, 8'd255);
    cfg(1'b0, 2'd3, 8'd2, 8'd2);
    pulse_start();
    push(8'd1); push(8'd2); push(8'd5); push(8'd9); push(8'd2);
    pulse_stop();
    pat = '{1, 0, 0, 1, 0, 1, 0, 1};
    exp5 = {16'd2, 16'd2, 16'd3, 16'd4};
    m = 0;
    for (int k = 0; k < 8; k++) begin
      out_ready = pat[k][0];
      chk("t5_valid", out_valid, 1'b1);
      chk("t5_idx", out_idx, m);
      chk("t5_count", out_count, exp5[m]);
      tick();
      if (pat[k] == 1) m++;
    end
    out_ready = 1'b0;
    chk("t5_done", done, 1'b1);
    chk("t5_idle", busy, 1'b0);
    settle();

    // Two-bin instance: basic drain length
    cfg(1'b1, 2'd0, 8'd0, 8'd3);
    cfg(1'b1, 2'd1, 8'd4, 8'd15);
    pulse_start();
    push(8'd0); push(8'd4); push(8'd1); push(8'd1);
    pulse_stop();
    out_ready = 1'b1;
    chk("t1_idx0", out_idx2, 1'b0);
    chk("t1_count0", out_count2, 4'd3);
    tick();
    chk("t1_idx1", out_idx2, 1'b1);
    chk("t1_count1", out_count2, 4'd1);
    chk("t1_no_done_early", done2, 1'b0);
    tick();
    chk("t1_done", done2, 1'b1);
    chk("t1_valid_end", out_valid2, 1'b0);
    tick();
    chk("t1_done_once", done2, 1'b0);
    settle();

    // Saturation on the 4-bit counter, then clear by a new start
    cfg(1'b1, 2'd0, 8'd0, 8'd255);
    cfg(1'b1, 2'd1, 8'd255, 8'd0);
    pulse_start();
    for (int i = 0; i < 20; i++) push(8'(i * 13));
    pulse_stop();
    chk("t3_count_sat", out_count2, 4'd15);
    chk("t3_sat_flag", out_sat2, 1'b1);
    out_ready = 1'b1;
    tick();
    chk("t3_bin1_count", out_count2, 4'd0);
    chk("t3_bin1_sat", out_sat2, 1'b0);
    settle();
    pulse_start();
    pulse_stop();
    chk("t3_clear_count", out_count2, 4'd0);
    chk("t3_clear_sat", out_sat2, 1'b0);
    settle();

    // Ignored cfg/start, then asynchronous reset mid-DRAIN and mid-ACCUM
    pulse_start();
    cfg(1'b0, 2'd0, 8'd200, 8'd201);
    push(8'd1); push(8'd2); push(8'd200);
    pulse_stop();
    chk("t6_cfg_ignored", out_count, 16'd2);
    pulse_start();
    chk("t6_start_ignored_valid", out_valid, 1'b1);
    chk("t6_start_ignored_idx", out_idx, 2'd0);
    chk("t6_start_ignored_s_ready", s_ready, 1'b0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t6_idx1_count", out_count, 16'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_drain_rst_valid", out_valid, 1'b0);
    chk("t6_drain_rst_idx", out_idx, 2'd0);
    chk("t6_drain_rst_count", out_count, 16'd0);
    chk("t6_drain_rst_busy", busy, 1'b0);
    chk("t6_drain_rst_done", done, 1'b0);
    rst_n = 1'b1;
    tick();
    pulse_start();
    push(8'd9);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_accum_rst_s_ready", s_ready, 1'b0);
    chk("t6_accum_rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    tick();
    pulse_start();
    push(8'd0); push(8'd0); push(8'd3);
    pulse_stop();
    drain4({16'd2, 16'd2, 16'd2, 16'd2}, "t6_bounds_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/stream_hist_bins.md
Name: stream_hist_bins

Overview:
Sequential, parametrised successor to the combinational histogram bin counter. It accepts a stream of unsigned samples over a valid/ready handshake and keeps one count per bin. Each bin has its own programmable inclusive range [lo, hi]. After a stop command, the block drains the bin counts one at a time over a second valid/ready handshake. It sits between a sample source, such as a pixel or ADC stream, and a downstream statistics consumer.

Parameters:
DATA_W, 8, sample and bound width in bits (unsigned)
NUM_BINS, 4, number of bins; must be >= 2
CNT_W, 16, per-bin counter width; counters saturate at 2^CNT_W-1
IDX_W (localparam), $clog2(NUM_BINS), width of bin index fields

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
cfg_we  in  1  bound write strobe; honoured only in IDLE
cfg_idx  in  IDX_W  bin being configured; writes with idx >= NUM_BINS are dropped
cfg_lo  in  DATA_W  inclusive lower bound
cfg_hi  in  DATA_W  inclusive upper bound
start  in  1  single-cycle pulse: clear counters and begin accumulating
stop  in  1  single-cycle pulse: end accumulation and begin drain
s_valid  in  1  sample valid
s_data  in  DATA_W  sample value
s_ready  out  1  high only in ACCUM
out_valid  out  1  bin result valid (DRAIN)
out_ready  in  1  consumer accepts result
out_idx  out  IDX_W  index of presented bin
out_count  out  CNT_W  count of presented bin
out_sat  out  1  presented bin's counter saturated
busy  out  1  state != IDLE
done  out  1  one-cycle pulse after last bin accepted

Behaviour:
- Reset values (async assert, sync release):
  - state=IDLE
  - all counts=0, all sat flags=0
  - all lo=0, all hi=0
  - s_ready=0, out_valid=0, out_idx=0, out_count=0, out_sat=0, busy=0, done=0
- FSM states IDLE, ACCUM, DRAIN. Outputs are registered or decoded from state.
- IDLE:
  - cfg_we writes lo/hi of cfg_idx on the clock edge.
  - start -> ACCUM. All counts and sat flags clear on that same edge.
  - stop alone is ignored.
  - start and stop in the same cycle: start wins.
  - Counts from the previous run are retained until the next start.
- ACCUM:
  - s_ready=1.
  - On each s_valid & s_ready edge, every bin with lo <= s_data <= hi (unsigned) increments.
  - Overlapping bins each count the same sample.
  - A bin with lo > hi never matches.
  - Counters update on the handshake edge and are visible the next cycle.
  - At 2^CNT_W-1 a counter holds its value and sets its sat flag.
  - cfg_we and start are ignored.
  - stop -> DRAIN. A sample handshaken in the same cycle as stop is counted.
  - s_ready=0 from the cycle after stop.
- DRAIN:
  - out_valid=1, beginning with out_idx=0.
  - out_count and out_sat reflect bin out_idx.
  - On out_valid & out_ready, out_idx increments.
  - Acceptance of bin NUM_BINS-1 -> IDLE: out_valid=0, out_idx=0, done=1 for exactly one cycle.
  - With out_ready held high, the drain takes NUM_BINS cycles. Back-pressure stalls it indefinitely with outputs stable.
  - start, stop, cfg_we and s_valid are ignored.
- rst_n low in any state aborts immediately to the reset values. There is no partial drain and no done pulse.

Test Plan:
1. Program bin0=[0,3], bin1=[4,15]; start; stream 0,4,1,1; stop; drain with out_ready=1 -> (idx0, count 3) then (idx1, count 1); done pulses once; 2 drain cycles beyond the first out_valid.
2. Program bin0=[0,9], bin1=[9,12], bin2=[20,10]; stream 1,12,3,11,9 -> bin0=3, bin1=3 (12, 11 and 9 count), bin2=0.
3. CNT_W=4, bin0=[0,255]; stream 20 samples -> out_count=15, out_sat=1. A following start clears to 0 and sat to 0.
4. Stop asserted in the same cycle as the handshake of sample 5 (bin0=[0,7]) -> that sample is counted; s_ready drops the next cycle; s_valid held high afterwards adds nothing.
5. Drain with out_ready toggling 1,0,0,1 -> out_idx/out_count stable while stalled; each index is delivered exactly once.
6. rst_n pulsed low mid-ACCUM and mid-DRAIN -> all outputs return to reset values asynchronously. cfg_we during ACCUM and start during DRAIN have no effect.
